// File: rtl/model_writing.sv
// NTM write head: streams memory row-major and applies erase-then-add,
// M[j][k] <= M[j][k]*(1 - w[j]*e[k]) + w[j]*a[k], in signed fixed point.
module model_writing #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 4,
  parameter int FRAC         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ready,
  output logic                 w_in_enable,
  output logic                 e_in_enable,
  output logic                 a_in_enable,
  output logic                 m_in_j_enable,
  output logic                 m_in_k_enable,
  output logic                 m_out_j_enable,
  output logic                 m_out_k_enable,
  input  logic [DATA_SIZE-1:0] size_n_in,
  input  logic [DATA_SIZE-1:0] size_w_in,
  input  logic [DATA_SIZE-1:0] w_in,
  input  logic [DATA_SIZE-1:0] e_in,
  input  logic [DATA_SIZE-1:0] a_in,
  input  logic [DATA_SIZE-1:0] m_in,
  output logic [DATA_SIZE-1:0] m_out
);

  localparam int D = DATA_SIZE;
  localparam logic [D-1:0] ONE    = D'(1) << FRAC;
  localparam logic [D-1:0] D_ONE  = D'(1);
  localparam logic [D-1:0] D_ZERO = '0;

  typedef enum logic [2:0] {IDLE, REQ, LOAD, MUL, UPD, OUT} state_t;

  state_t state, state_next;

  logic [D-1:0] size_n, size_w, j, k;
  logic [D-1:0] w_reg, e_reg, a_reg, m_reg;
  logic [D-1:0] we, wa, m_new;

  logic accept, last_k, last_j;
  logic req_d, first_k_d, out_d, out_j_d, ready_d;

  assign accept = (state == IDLE) && ready && start &&
                  (size_n_in != D_ZERO) && (size_w_in != D_ZERO);
  assign last_k = (k == size_w - D_ONE);
  assign last_j = (j == size_n - D_ONE);

  function automatic logic signed [2*D-1:0] sext(input logic [D-1:0] x);
    return {{D{x[D-1]}}, x};
  endfunction

  // Full-width signed products; the kept field is the product shifted right by FRAC.
  logic signed [2*D-1:0] we_prod, wa_prod, upd_prod;
  logic [D-1:0] keep_frac;

  assign keep_frac = ONE - we;
  assign we_prod   = sext(w_reg) * sext(e_reg);
  assign wa_prod   = sext(w_reg) * sext(a_reg);
  assign upd_prod  = sext(m_reg) * sext(keep_frac);

  logic unused_bits;
  assign unused_bits = ^{we_prod, wa_prod, upd_prod, 32'(CONTROL_SIZE)};

  // NOTE: state and all registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = REQ;
      REQ:     state_next = LOAD;
      LOAD:    state_next = MUL;
      MUL:     state_next = UPD;
      UPD:     state_next = OUT;
      OUT:     state_next = (last_k && last_j) ? IDLE : REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_d     = (state == REQ);
    first_k_d = (state == REQ) && (k == D_ZERO);
    out_d     = (state == OUT);
    out_j_d   = (state == OUT) && last_k;
    ready_d   = (state == IDLE) && !accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready          <= 1'b1;
      w_in_enable    <= 1'b0;
      e_in_enable    <= 1'b0;
      a_in_enable    <= 1'b0;
      m_in_j_enable  <= 1'b0;
      m_in_k_enable  <= 1'b0;
      m_out_j_enable <= 1'b0;
      m_out_k_enable <= 1'b0;
    end else begin
      ready          <= ready_d;
      w_in_enable    <= first_k_d;
      e_in_enable    <= req_d;
      a_in_enable    <= req_d;
      m_in_j_enable  <= first_k_d;
      m_in_k_enable  <= req_d;
      m_out_j_enable <= out_j_d;
      m_out_k_enable <= out_d;
    end
  end

  // NOTE: the datapath registers are ordinary flops, not memories, so all of
  // them take the asynchronous reset and an aborted run leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_n <= '0;
      size_w <= '0;
      j      <= '0;
      k      <= '0;
      w_reg  <= '0;
      e_reg  <= '0;
      a_reg  <= '0;
      m_reg  <= '0;
      we     <= '0;
      wa     <= '0;
      m_new  <= '0;
      m_out  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          size_n <= size_n_in;
          size_w <= size_w_in;
          j      <= '0;
          k      <= '0;
        end
        LOAD: begin
          m_reg <= m_in;
          e_reg <= e_in;
          a_reg <= a_in;
          if (k == D_ZERO) w_reg <= w_in;
        end
        MUL: begin
          we <= we_prod[FRAC +: D];
          wa <= wa_prod[FRAC +: D];
        end
        UPD: m_new <= upd_prod[FRAC +: D] + wa;
        OUT: begin
          m_out <= m_new;
          if (!last_k) begin
            k <= k + D_ONE;
          end else if (!last_j) begin
            j <= j + D_ONE;
            k <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_model_writing.sv
// Self-checking bench for model_writing: a bench-side controller feeds w/e/a/M
// on request, and every updated element is compared with a fixed-point model.
module tb_model_writing;

  localparam int D    = 64;
  localparam int FRAC = 32;
  localparam logic [D-1:0] ONE = 64'h1_0000_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         ready;
  logic         w_in_enable, e_in_enable, a_in_enable;
  logic         m_in_j_enable, m_in_k_enable;
  logic         m_out_j_enable, m_out_k_enable;
  logic [D-1:0] size_n_in = '0, size_w_in = '0;
  logic [D-1:0] w_in = '0, e_in = '0, a_in = '0, m_in = '0;
  logic [D-1:0] m_out;

  model_writing #(.DATA_SIZE(D), .CONTROL_SIZE(4), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .w_in_enable(w_in_enable), .e_in_enable(e_in_enable), .a_in_enable(a_in_enable),
    .m_in_j_enable(m_in_j_enable), .m_in_k_enable(m_in_k_enable),
    .m_out_j_enable(m_out_j_enable), .m_out_k_enable(m_out_k_enable),
    .size_n_in(size_n_in), .size_w_in(size_w_in),
    .w_in(w_in), .e_in(e_in), .a_in(a_in), .m_in(m_in), .m_out(m_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: floor(x*y / 2^FRAC), wrapped to D bits.
  function automatic logic [D-1:0] fx_mul(input logic [D-1:0] x, input logic [D-1:0] y);
    logic signed [2*D-1:0] p;
    p = $signed({{D{x[D-1]}}, x}) * $signed({{D{y[D-1]}}, y});
    return D'(p >>> FRAC);
  endfunction

  function automatic logic [D-1:0] model_elem(input logic [D-1:0] m, input logic [D-1:0] w,
                                              input logic [D-1:0] e, input logic [D-1:0] a);
    return fx_mul(m, ONE - fx_mul(w, e)) + fx_mul(w, a);
  endfunction

  // Memory image and vectors served by the bench-side controller.
  logic [D-1:0] m_mem [4][4];
  logic [D-1:0] w_mem [4];
  logic [D-1:0] e_mem [4];
  logic [D-1:0] a_mem [4];
  int cur_n = 1, cur_w = 1;

  int req_idx = 0;
  int cnt_mink, cnt_minj, cnt_w, cnt_e, cnt_a, cnt_moutk, cnt_moutj, bad_cnt;
  int first_out_cyc = -1;
  logic [D-1:0] out_q[$];
  logic         outj_q[$];

  task automatic clear_monitor();
    req_idx = 0; cnt_mink = 0; cnt_minj = 0; cnt_w = 0; cnt_e = 0; cnt_a = 0;
    cnt_moutk = 0; cnt_moutj = 0; bad_cnt = 0; first_out_cyc = -1;
    out_q.delete(); outj_q.delete();
  endtask

  // Controller: answers requests on the following negedge, scrambles idle inputs,
  // and records every output pulse.
  initial begin
    int jj, kk;
    bit grp_req, grp_out;
    clear_monitor();
    forever begin
      @(negedge clk);
      grp_req = m_in_k_enable | m_in_j_enable | w_in_enable | e_in_enable | a_in_enable;
      grp_out = m_out_k_enable | m_out_j_enable;
      if (grp_req && grp_out) bad_cnt++;
      if (m_in_k_enable) cnt_mink++;
      if (m_in_j_enable) cnt_minj++;
      if (w_in_enable)   cnt_w++;
      if (e_in_enable)   cnt_e++;
      if (a_in_enable)   cnt_a++;
      if (m_out_j_enable) cnt_moutj++;
      if (w_in_enable != m_in_j_enable) bad_cnt++;
      if ((e_in_enable != m_in_k_enable) || (a_in_enable != m_in_k_enable)) bad_cnt++;
      if (m_in_k_enable && req_idx < cur_n * cur_w) begin
        jj = req_idx / cur_w;
        kk = req_idx % cur_w;
        if (m_in_j_enable != (kk == 0)) bad_cnt++;
        m_in = m_mem[jj][kk];
        e_in = e_mem[kk];
        a_in = a_mem[kk];
        w_in = w_in_enable ? w_mem[jj] : {$urandom, $urandom};
        req_idx++;
      end else begin
        if (m_in_k_enable || m_in_j_enable) bad_cnt++;
        m_in = {$urandom, $urandom};
        e_in = {$urandom, $urandom};
        a_in = {$urandom, $urandom};
        w_in = {$urandom, $urandom};
      end
      if (m_out_k_enable) begin
        cnt_moutk++;
        out_q.push_back(m_out);
        outj_q.push_back(m_out_j_enable);
        if (first_out_cyc < 0) first_out_cyc = cyc;
      end else if (m_out_j_enable) begin
        bad_cnt++;
      end
    end
  end

  task automatic fill_random(input int n, input int w);
    for (int jr = 0; jr < n; jr++) begin
      w_mem[jr] = {$urandom, $urandom};
      for (int kc = 0; kc < w; kc++) m_mem[jr][kc] = {$urandom, $urandom};
    end
    for (int kc = 0; kc < w; kc++) begin
      e_mem[kc] = {$urandom, $urandom};
      a_mem[kc] = {$urandom, $urandom};
    end
  endtask

  task automatic run_op(input string name, input int n, input int w, input bit busy_start);
    int start_cyc;
    bit done;
    logic [D-1:0] exp_v;
    cur_n = n;
    cur_w = w;
    clear_monitor();
    @(negedge clk);
    size_n_in = D'(n);
    size_w_in = D'(w);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    size_n_in = {$urandom, $urandom};
    size_w_in = {$urandom, $urandom};
    start_cyc = cyc;
    check({name, "_ready_low"}, D'(ready), D'(0));
    if (busy_start) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      size_n_in = 64'd3;
      size_w_in = 64'd3;
      @(negedge clk);
      start = 1'b0;
    end
    done = 1'b0;
    for (int i = 0; i < 5 * n * w + 40 && !done; i++) begin
      if (ready) done = 1'b1;
      else @(negedge clk);
    end
    check({name, "_finished"}, D'(done), D'(1));
    check({name, "_ready_latency"}, D'(cyc - start_cyc), D'(5 * n * w + 1));
    check({name, "_first_out_latency"}, D'(first_out_cyc - start_cyc), D'(5));
    check({name, "_m_in_k_count"}, D'(cnt_mink), D'(n * w));
    check({name, "_e_a_counts"}, D'(cnt_e + cnt_a), D'(2 * n * w));
    check({name, "_m_in_j_count"}, D'(cnt_minj), D'(n));
    check({name, "_w_in_count"}, D'(cnt_w), D'(n));
    check({name, "_m_out_k_count"}, D'(cnt_moutk), D'(n * w));
    check({name, "_m_out_j_count"}, D'(cnt_moutj), D'(n));
    check({name, "_protocol_violations"}, D'(bad_cnt), D'(0));
    for (int idx = 0; idx < n * w && idx < out_q.size(); idx++) begin
      exp_v = model_elem(m_mem[idx / w][idx % w], w_mem[idx / w], e_mem[idx % w], a_mem[idx % w]);
      check($sformatf("%s_m_out[%0d][%0d]", name, idx / w, idx % w), out_q[idx], exp_v);
      check($sformatf("%s_row_end[%0d]", name, idx), D'(outj_q[idx]), D'((idx % w) == w - 1));
    end
    if (out_q.size() == n * w)
      check({name, "_m_out_hold"}, m_out, out_q[n * w - 1]);
  endtask

  initial begin
    int saved;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", D'(ready), D'(1));
    check("reset_m_out", m_out, '0);
    check("reset_enables", D'({w_in_enable, e_in_enable, a_in_enable, m_in_j_enable,
                                m_in_k_enable, m_out_j_enable, m_out_k_enable}), D'(0));
    @(negedge clk);
    rst = 1'b0;

    // Full erase then add: 2 -> 3 (in units of ONE).
    m_mem[0][0] = 2 * ONE; w_mem[0] = ONE; e_mem[0] = ONE; a_mem[0] = 3 * ONE;
    run_op("full_erase", 1, 1, 1'b0);
    if (out_q.size() > 0) check("full_erase_const", out_q[0], 3 * ONE);

    // Zero weighting leaves memory untouched.
    fill_random(2, 3);
    for (int jr = 0; jr < 2; jr++) begin
      w_mem[jr] = '0;
      for (int kc = 0; kc < 3; kc++) m_mem[jr][kc] = D'(jr * 16 + kc) << FRAC;
    end
    run_op("zero_weight", 2, 3, 1'b0);
    if (out_q.size() == 6) check("zero_weight_last", out_q[5], D'(18) << FRAC);

    // Half erase, half add: 4 -> 3.
    m_mem[0][0] = 4 * ONE; w_mem[0] = ONE / 2; e_mem[0] = ONE; a_mem[0] = 2 * ONE;
    run_op("half", 1, 1, 1'b0);
    if (out_q.size() > 0) check("half_const", out_q[0], 3 * ONE);

    // Signed: -2 with no erase plus -1 -> -3.
    m_mem[0][0] = -(2 * ONE); w_mem[0] = ONE; e_mem[0] = '0; a_mem[0] = -ONE;
    run_op("signed", 1, 1, 1'b0);
    if (out_q.size() > 0) check("signed_const", out_q[0], 64'hFFFF_FFFD_0000_0000);

    // Reset during the third element of a 2x2 run.
    fill_random(2, 2);
    cur_n = 2; cur_w = 2;
    clear_monitor();
    @(negedge clk);
    size_n_in = 64'd2; size_w_in = 64'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && out_q.size() < 2; i++) @(negedge clk);
    check("abort_reached_elem3", D'(out_q.size()), D'(2));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_enables", D'({w_in_enable, e_in_enable, a_in_enable, m_in_j_enable,
                               m_in_k_enable, m_out_j_enable, m_out_k_enable}), D'(0));
    check("abort_m_out", m_out, '0);
    check("abort_ready", D'(ready), D'(1));
    @(negedge clk);
    rst = 1'b0;
    saved = cnt_mink + cnt_moutk + cnt_minj + cnt_moutj;
    repeat (12) @(negedge clk);
    check("abort_silent", D'(cnt_mink + cnt_moutk + cnt_minj + cnt_moutj), D'(saved));
    fill_random(2, 2);
    run_op("after_abort", 2, 2, 1'b0);

    // START with a zero size in IDLE is ignored.
    clear_monitor();
    @(negedge clk);
    size_n_in = 64'd2; size_w_in = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zero_size_ready", D'(ready), D'(1));
    repeat (10) @(negedge clk);
    check("zero_size_no_pulses", D'(cnt_mink + cnt_minj + cnt_moutk + cnt_moutj), D'(0));

    // START while busy is ignored; random data and shapes.
    fill_random(2, 2);
    run_op("busy_start", 2, 2, 1'b1);
    for (int r = 0; r < 4; r++) begin
      int n, w;
      n = $urandom_range(1, 4);
      w = $urandom_range(1, 4);
      fill_random(n, w);
      run_op($sformatf("rand%0d", r), n, w, r[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
